// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: steps a shared 3-input evaluator through all 8 input
// combinations. Both outputs are captured into truth tables, which are
// compared against expected tables latched when the sweep is accepted.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_sop,
    input  logic [7:0] exp_pos,
    output logic       eval_a,
    output logic       eval_b,
    output logic       eval_c,
    input  logic       eval_sop,
    input  logic       eval_pos,
    output logic       busy,
    output logic       done,
    output logic [7:0] sop_tt,
    output logic [7:0] pos_tt,
    output logic       mismatch,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [3:0] settle_q;
    logic [7:0] exp_sop_q;
    logic [7:0] exp_pos_q;
    logic [7:0] diff;
    logic [2:0] first_diff;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort takes priority over start and over sampling
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort)                        state_d = S_IDLE;
                else if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)              state_d = S_IDLE;
                else if (idx_q == 3'd7) state_d = S_DONE;
                else                    state_d = S_WAIT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Compare the completed tables (last bit taken live from the evaluator)
    // so the verdict can be registered on the SAMPLE->DONE edge
    always_comb begin
        diff       = ({eval_sop, sop_tt[6:0]} ^ exp_sop_q) |
                     ({eval_pos, pos_tt[6:0]} ^ exp_pos_q);
        first_diff = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (diff[i-1]) first_diff = 3'(i - 1);
        end
    end

    // Sweep datapath: index, settle counter, captured tables and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            settle_q       <= '0;
            exp_sop_q      <= '0;
            exp_pos_q      <= '0;
            sop_tt         <= '0;
            pos_tt         <= '0;
            mismatch       <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx_q          <= '0;
                        settle_q       <= '0;
                        exp_sop_q      <= exp_sop;
                        exp_pos_q      <= exp_pos;
                        sop_tt         <= '0;
                        pos_tt         <= '0;
                        mismatch       <= 1'b0;
                        first_fail_idx <= '0;
                    end
                end
                S_WAIT: begin
                    if (!abort) settle_q <= settle_q + 4'd1;
                end
                S_SAMPLE: begin
                    if (!abort) begin
                        sop_tt[idx_q] <= eval_sop;
                        pos_tt[idx_q] <= eval_pos;
                        settle_q      <= '0;
                        if (idx_q == 3'd7) begin
                            mismatch       <= |diff;
                            first_fail_idx <= first_diff;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Evaluator drive and status flags decoded from the state
    always_comb begin
        busy = (state_q == S_WAIT) || (state_q == S_SAMPLE);
        done = (state_q == S_DONE);
        case (state_q)
            S_IDLE:  {eval_a, eval_b, eval_c} = 3'b000;
            S_DONE:  {eval_a, eval_b, eval_c} = 3'b111;
            default: {eval_a, eval_b, eval_c} = idx_q;
        endcase
    end

endmodule
